// File: rtl/life_pkg.sv
// Shared types and constants for the next-generation row engine.
// Holds the FSM states, the default rule masks and the neighbour counter.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } lifeState_t;

  // B3/S23: the classic rule
  localparam logic [8:0] DEFAULT_BIRTH   = 9'b000001000;
  localparam logic [8:0] DEFAULT_SURVIVE = 9'b000001100;

  localparam int NBR_BITS = 4;

  function automatic logic [NBR_BITS-1:0] countOnes8(input logic [7:0] v);
    logic [NBR_BITS-1:0] sum;
    sum = '0;
    for (int i = 0; i < 8; i++) sum = sum + {{(NBR_BITS-1){1'b0}}, v[i]};
    return sum;
  endfunction

endpackage

// File: rtl/life_cell.sv
// One cell of the automaton: counts the 8 neighbours of mid[1] and
// applies the birth/survive masks. Purely combinational.
module life_cell
  import life_pkg::*;
(
  input  logic [2:0] above,
  input  logic [2:0] mid,
  input  logic [2:0] below,
  input  logic [8:0] birthMask,
  input  logic [8:0] surviveMask,
  output logic       next
);

  logic [NBR_BITS-1:0] n;

  assign n    = countOnes8({above, mid[2], mid[0], below});
  assign next = mid[1] ? surviveMask[n] : birthMask[n];

endmodule

// File: rtl/life_row_engine.sv
// Three-row window plus chunked next-generation evaluator. The middle row
// is evaluated CELLS_PER_CYCLE cells per clock, then offered for write-back.
module life_row_engine
  import life_pkg::*;
#(
  parameter int         WIDTH           = 640,
  parameter int         COL_BITS        = 10,
  parameter int         CELLS_PER_CYCLE = 8,
  parameter logic [8:0] BIRTH_MASK      = DEFAULT_BIRTH,
  parameter logic [8:0] SURVIVE_MASK    = DEFAULT_SURVIVE,
  parameter bit         WRAP            = 1'b1
) (
  input  logic                clkDiv,
  input  logic                rst,
  input  logic                flush,
  input  logic                readValid,
  input  logic [WIDTH-1:0]    readRow,
  output logic                readReady,
  input  logic                seed,
  input  logic                noise,
  input  logic                drawRequest,
  input  logic [COL_BITS-1:0] column,
  output logic [WIDTH-1:0]    writeRow,
  output logic                writeValid,
  input  logic                writeReady,
  output logic [WIDTH-1:0]    drawRow
);

  localparam int CPC        = CELLS_PER_CYCLE;
  localparam int K          = WIDTH / CPC;
  localparam int CHUNK_BITS = (K > 1) ? $clog2(K) : 1;
  localparam int EXT_BITS   = $clog2(WIDTH + 2);
  localparam int ROW_BITS   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CHUNK_BITS-1:0] LAST_CHUNK = CHUNK_BITS'(K - 1);

  typedef struct packed {
    logic                seed;
    logic                draw;
    logic [COL_BITS-1:0] column;
  } pushReq_t;

  lifeState_t            state, stateNext;
  logic [CHUNK_BITS-1:0] chunk;
  logic [1:0]            fill;
  logic [WIDTH-1:0]      rowA, rowB, rowC;
  pushReq_t              req;
  logic                  push;

  assign push    = readValid && readReady;
  assign drawRow = rowB;

  // FSM
  always_ff @(posedge clkDiv) begin
    if (!rst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    readReady  = 1'b0;
    writeValid = 1'b0;
    case (state)
      IDLE: begin
        readReady = 1'b1;
        if (readValid && fill[1]) stateNext = COMPUTE;
      end
      COMPUTE: if (chunk == LAST_CHUNK) stateNext = COMPUTE == state ? OUTPUT : state;
      OUTPUT: begin
        writeValid = 1'b1;
        if (writeReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
    if (flush) stateNext = IDLE;
  end

  // Column -1 sits at bit 0 and column WIDTH at the top of the extended row
  function automatic logic [WIDTH+1:0] extend(input logic [WIDTH-1:0] r);
    return WRAP ? {r[0], r, r[WIDTH-1]} : {1'b0, r, 1'b0};
  endfunction

  logic [WIDTH+1:0]  extA, extB, extC;
  logic [EXT_BITS-1:0] extBase;
  logic [ROW_BITS-1:0] rowBase;
  logic [CPC+1:0]    winA, winB, winC;
  logic [CPC-1:0]    chunkNext;

  assign extA    = extend(rowA);
  assign extB    = extend(rowB);
  assign extC    = extend(rowC);
  assign extBase = EXT_BITS'(chunk) * EXT_BITS'(CPC);
  assign rowBase = ROW_BITS'(chunk) * ROW_BITS'(CPC);
  assign winA    = extA[extBase +: CPC+2];
  assign winB    = extB[extBase +: CPC+2];
  assign winC    = extC[extBase +: CPC+2];

  for (genvar lane = 0; lane < CPC; lane++) begin : gLane
    logic                ruleNext;
    logic [COL_BITS-1:0] cellCol;

    life_cell uCell (
      .above      (winA[lane +: 3]),
      .mid        (winB[lane +: 3]),
      .below      (winC[lane +: 3]),
      .birthMask  (BIRTH_MASK),
      .surviveMask(SURVIVE_MASK),
      .next       (ruleNext)
    );

    // cellCol is always < WIDTH, so an out-of-range column never matches
    assign cellCol         = COL_BITS'(chunk) * COL_BITS'(CPC) + COL_BITS'(lane);
    assign chunkNext[lane] = (req.draw && (req.column == cellCol)) ||
                             (req.seed ? noise : ruleNext);
  end

  // Window, fill counter, captured request and result row
  always_ff @(posedge clkDiv) begin
    if (!rst) begin
      rowA     <= '0;
      rowB     <= '0;
      rowC     <= '0;
      fill     <= '0;
      chunk    <= '0;
      req      <= '0;
      writeRow <= '0;
    end else if (flush) begin
      rowA  <= '0;
      rowB  <= '0;
      rowC  <= '0;
      fill  <= '0;
      chunk <= '0;
    end else begin
      if (push) begin
        rowA  <= rowB;
        rowB  <= rowC;
        rowC  <= readRow;
        if (fill != 2'd3) fill <= fill + 2'd1;
        req   <= '{seed: seed, draw: drawRequest, column: column};
        chunk <= '0;
      end
      if (state == COMPUTE) begin
        writeRow[rowBase +: CPC] <= chunkNext;
        chunk                    <= chunk + CHUNK_BITS'(1);
      end
    end
  end

endmodule
